// File: rtl/lab5_rx_pkg.sv
// Shared types and default timing constants for the pulse-distance command receiver.
package lab5_rx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

   localparam int WIDTH_DEF         = 12;
   localparam int ONE_MIN_GAP_DEF   = 4;
   localparam int BIT_MIN_GAP_DEF   = 2;
   localparam int START_MIN_GAP_DEF = 8;
   localparam int GAP_MAX_DEF       = 15;

   // Number of bits needed to hold values 0..maxval
   function automatic int cnt_width(input int maxval);
      return $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/pulse_gap_counter.sv
// Line front end: registers the serial input, flags low-to-high transitions
// and counts consecutive low samples with saturation.
module pulse_gap_counter #(
   parameter int GAP_MAX = 15,
   parameter int GW      = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          data,
   output logic          rise,
   output logic [GW-1:0] gap
);

   logic          data_q;
   logic [GW-1:0] gap_cnt;

   // Track the previous sample and the length of the current low run; frozen while en=0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= 1'b1;
         gap_cnt <= '0;
      end else if (en) begin
         data_q <= data;
         if (data) begin
            gap_cnt <= '0;
         end else if (gap_cnt != GW'(GAP_MAX)) begin
            gap_cnt <= gap_cnt + GW'(1);
         end
      end
   end

   // A rise is only seen on an enabled cycle, so a transition that happened while
   // frozen is reported as soon as en returns (data_q still holds the old low).
   assign rise = en & data & ~data_q;
   assign gap  = gap_cnt;

endmodule

// File: rtl/lab5_shift_top.sv
// Pulse-distance command receiver: decodes gap lengths into bits, assembles
// WIDTH-bit frames MSB first and publishes only complete frames on command.
module lab5_shift_top
   import lab5_rx_pkg::*;
#(
   parameter int WIDTH         = WIDTH_DEF,
   parameter int ONE_MIN_GAP   = ONE_MIN_GAP_DEF,
   parameter int BIT_MIN_GAP   = BIT_MIN_GAP_DEF,
   parameter int START_MIN_GAP = START_MIN_GAP_DEF,
   parameter int GAP_MAX       = GAP_MAX_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data,
   input  logic             en,
   output logic [WIDTH-1:0] command
);

   localparam int GW = cnt_width(GAP_MAX);
   localparam int BW = cnt_width(WIDTH);

   rx_state_t        state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             rise;
   logic [GW-1:0]    gap;
   logic             new_bit;
   logic [WIDTH-1:0] next_word;

   pulse_gap_counter #(
      .GAP_MAX (GAP_MAX),
      .GW      (GW)
   ) u_gap (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .data  (data),
      .rise  (rise),
      .gap   (gap)
   );

   assign new_bit   = (gap >= GW'(ONE_MIN_GAP));
   assign next_word = {shreg[WIDTH-2:0], new_bit};

   // Frame FSM: start gaps (re)open a frame from either state, bit gaps shift in,
   // glitch gaps abort, and the final bit publishes the word on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         command <= '0;
      end else if (rise) begin
         if (gap >= GW'(START_MIN_GAP)) begin
            state   <= RECV;
            shreg   <= '0;
            bit_cnt <= '0;
         end else if (state == RECV) begin
            if (gap < GW'(BIT_MIN_GAP)) begin
               state   <= IDLE;
               bit_cnt <= '0;
            end else if (bit_cnt == BW'(WIDTH - 1)) begin
               command <= next_word;
               shreg   <= next_word;
               state   <= IDLE;
               bit_cnt <= '0;
            end else begin
               shreg   <= next_word;
               bit_cnt <= bit_cnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_lab5_shift_top.sv
// Directed bench for the pulse-distance command receiver.
module tb_lab5_shift_top;

   logic        clk;
   logic        reset;
   logic        data;
   logic        en;
   logic [11:0] command;

   int errors = 0;
   int checks = 0;

   lab5_shift_top dut (
      .clk     (clk),
      .reset   (reset),
      .data    (data),
      .en      (en),
      .command (command)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%03h expected=0x%03h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%03h", tag, got);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // g low cycles followed by a one-cycle high pulse
   task automatic send_gap(input int g);
      data = 1'b0;
      repeat (g) tick();
      data = 1'b1;
      tick();
   endtask

   task automatic send_bits(input logic [11:0] word, input int hi, input int lo,
                            input int one_g, input int zero_g);
      for (int i = hi; i >= lo; i--) send_gap(word[i] ? one_g : zero_g);
   endtask

   task automatic send_frame(input logic [11:0] word, input int one_g, input int zero_g,
                             input int start_g);
      send_gap(start_g);
      send_bits(word, 11, 0, one_g, zero_g);
   endtask

   initial begin
      reset = 1'b0;
      data  = 1'b1;
      en    = 1'b1;
      #23;
      check("reset_cmd", command, 12'h000);
      tick();
      reset = 1'b1;
      tick();
      check("idle_hi_rise0", {11'd0, dut.rise}, 12'h000);
      tick();
      check("idle_hi_rise1", {11'd0, dut.rise}, 12'h000);
      check("idle_hi_cmd", command, 12'h000);

      // gaps 5,3,3,5,3,3,3,5,3,3,3,3 -> 0x910
      send_gap(10);
      send_bits(12'h910, 11, 1, 5, 3);
      check("t2_hold_11bits", command, 12'h000);
      send_bits(12'h910, 0, 0, 5, 3);
      check("t2_frame_910", command, 12'h910);

      send_frame(12'hFFF, 5, 3, 10);
      check("t3_all_ones", command, 12'hFFF);
      send_frame(12'h000, 5, 3, 10);
      check("t3_all_zeros", command, 12'h000);
      send_frame(12'hAAA, 4, 3, 8);
      check("t3_gap4_gap3", command, 12'hAAA);
      send_frame(12'h5A5, 4, 2, 9);
      check("t3_gap2_is_zero", command, 12'h5A5);
      send_frame(12'h3C3, 7, 3, 15);
      check("t3_gap7_is_one", command, 12'h3C3);

      // restart after 6 bits: needs a full 12 new bits
      send_gap(10);
      send_bits(12'hFFF, 11, 6, 5, 3);
      send_gap(9);
      check("t4_after_restart", command, 12'h3C3);
      send_bits(12'h123, 11, 6, 5, 3);
      check("t4_6_new_bits", command, 12'h3C3);
      send_bits(12'h123, 5, 0, 5, 3);
      check("t4_new_frame", command, 12'h123);

      // 1-cycle gap aborts; following bit pulses are ignored
      send_gap(10);
      send_bits(12'hFFF, 11, 7, 5, 3);
      send_gap(1);
      send_bits(12'hFFF, 11, 0, 5, 3);
      check("t5_abort_hold", command, 12'h123);
      send_frame(12'h0F0, 5, 3, 40);
      check("t5_sat_start", command, 12'h0F0);

      // en=0 inside a gap, and a rise occurring while frozen
      send_gap(10);
      data = 1'b0;
      repeat (2) tick();
      en = 1'b0;
      repeat (7) tick();
      en = 1'b1;
      repeat (3) tick();
      data = 1'b1;
      tick();
      data = 1'b0;
      repeat (3) tick();
      en = 1'b0;
      data = 1'b1;
      repeat (4) tick();
      check("t6_frozen_cmd", command, 12'h0F0);
      en = 1'b1;
      tick();
      send_bits(12'h801, 9, 0, 5, 3);
      check("t6_en_gap", command, 12'h801);

      // async reset mid-frame clears command without a clock edge
      send_gap(10);
      send_bits(12'hFFF, 11, 8, 5, 3);
      reset = 1'b0;
      #2;
      check("t6_async_reset", command, 12'h000);
      tick();
      reset = 1'b1;
      send_bits(12'hFFF, 7, 0, 5, 3);
      check("t6_no_frame_after_reset", command, 12'h000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
